// File: rtl/mem_dp_param.sv
// Dual-port synchronous memory: port A read-only, port B read/write with byte enables.
// A clear sequencer zeroes every entry after reset before requests are accepted.
module mem_dp_param #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned RD_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            a_req,
  input  logic [AW-1:0]   a_addr,
  output logic [DW-1:0]   a_rdata,
  output logic            a_valid,
  output logic            a_err,
  input  logic            b_req,
  input  logic            b_wen,
  input  logic [DW/8-1:0] b_be,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  output logic [DW-1:0]   b_rdata,
  output logic            b_valid,
  output logic            b_err
);

  localparam int unsigned NB      = DW / 8;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          w_clr_we;
  logic          r_ready;
  logic [DW-1:0] r_mem [DEPTH];

  logic          r_a_valid, r_a_err, r_b_valid, r_b_err;
  logic [DW-1:0] r_a_rdata, r_b_rdata;

  logic          w_a_acc, w_a_in, w_b_acc, w_b_in, w_b_we, w_col;
  logic [DW-1:0] w_a_old, w_b_old, w_b_new, w_a_data, w_b_data;

  // Clear sequencer: one entry per edge until the last one is written
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      S_INIT: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == LAST) w_state_nxt = S_READY;
      end
      S_READY: w_state_nxt = S_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == S_READY);
    end
  end

  // Request decode, byte-lane merge and collision resolution
  always_comb begin
    w_a_acc = a_req & r_ready;
    w_b_acc = b_req & r_ready;
    w_a_in  = ({1'b0, a_addr} < DEPTH_L);
    w_b_in  = ({1'b0, b_addr} < DEPTH_L);
    w_b_we  = w_b_acc & b_wen & w_b_in;
    w_a_old = r_mem[a_addr];
    w_b_old = r_mem[b_addr];
    w_b_new = w_b_old;
    for (int i = 0; i < int'(NB); i++) begin
      if (b_wen && b_be[i]) w_b_new[8*i +: 8] = b_wdata[8*i +: 8];
    end
    w_col    = w_b_we & (a_addr == b_addr);
    w_a_data = '0;
    w_b_data = '0;
    if (w_a_in) w_a_data = (RD_MODE != 0 && w_col) ? w_b_new : w_a_old;
    if (w_b_in) w_b_data = (RD_MODE != 0) ? w_b_new : w_b_old;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_valid <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_valid <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_rdata <= '0;
    end else begin
      r_a_valid <= w_a_acc;
      r_b_valid <= w_b_acc;
      if (w_a_acc) begin
        r_a_err   <= ~w_a_in;
        r_a_rdata <= w_a_data;
      end
      if (w_b_acc) begin
        r_b_err   <= ~w_b_in;
        r_b_rdata <= w_b_data;
      end
    end
  end

  // Storage has no reset; the sequencer and port B are mutually exclusive writers
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[r_cnt] <= '0;
    else if (w_b_we) r_mem[b_addr] <= w_b_new;
  end

  assign ready   = r_ready;
  assign a_valid = r_a_valid;
  assign a_err   = r_a_err;
  assign a_rdata = r_a_rdata;
  assign b_valid = r_b_valid;
  assign b_err   = r_b_err;
  assign b_rdata = r_b_rdata;

endmodule

// File: tb/tb_mem_dp_param.sv
// Bench for mem_dp_param: two instances (DEPTH=256 read-first, DEPTH=200 write-first)
// share one stimulus stream and are checked against vector tables and a reference model.
module tb_mem_dp_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req, b_req, b_wen;
  logic [7:0]  a_addr, b_addr;
  logic [1:0]  b_be;
  logic [15:0] b_wdata;

  logic        rdy0, av0, ae0, bv0, berr0;
  logic [15:0] ad0, bd0;
  logic        rdy1, av1, ae1, bv1, berr1;
  logic [15:0] ad1, bd1;

  mem_dp_param #(.DW(16), .AW(8), .DEPTH(256), .RD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .ready(rdy0),
    .a_req(a_req), .a_addr(a_addr), .a_rdata(ad0), .a_valid(av0), .a_err(ae0),
    .b_req(b_req), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(bd0), .b_valid(bv0), .b_err(berr0)
  );

  mem_dp_param #(.DW(16), .AW(8), .DEPTH(200), .RD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .ready(rdy1),
    .a_req(a_req), .a_addr(a_addr), .a_rdata(ad1), .a_valid(av1), .a_err(ae1),
    .b_req(b_req), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(bd1), .b_valid(bv1), .b_err(berr1)
  );

  typedef struct packed {
    logic        av;
    logic        ae;
    logic [15:0] ad;
    logic        bv;
    logic        be;
    logic [15:0] bd;
  } exp_t;

  typedef struct {
    logic        a_req;
    logic [7:0]  a_addr;
    logic        b_req;
    logic        b_wen;
    logic [1:0]  b_be;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata;
    exp_t        e0;
    exp_t        e1;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m0 [256];
  logic [15:0] m1 [256];

  function automatic exp_t mk(logic av, logic ae, logic [15:0] ad, logic bv, logic be, logic [15:0] bd);
    exp_t e;
    e.av = av; e.ae = ae; e.ad = ad; e.bv = bv; e.be = be; e.bd = bd;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic ar, input logic [7:0] aa, input logic br, input logic bw,
                       input logic [1:0] bb, input logic [7:0] ba, input logic [15:0] bd);
    a_req = ar; a_addr = aa; b_req = br; b_wen = bw; b_be = bb; b_addr = ba; b_wdata = bd;
  endtask

  task automatic drive_random();
    drive(1'(($urandom % 4) != 0), 8'($urandom_range(0, 255)), 1'(($urandom % 4) != 0),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
          16'($urandom));
    if (($urandom % 4) == 0) b_addr = a_addr;
  endtask

  // Reference: plain memory arrays updated from the request rules
  task automatic model_step(input int d, output exp_t e);
    int          depth;
    bit          mode, a_in, b_in, bwe;
    logic [15:0] old_a, old_b, nw;
    depth = (d == 0) ? 256 : 200;
    mode  = (d != 0);
    a_in  = int'(a_addr) < depth;
    b_in  = int'(b_addr) < depth;
    old_a = (d == 0) ? m0[a_addr] : m1[a_addr];
    old_b = (d == 0) ? m0[b_addr] : m1[b_addr];
    nw    = old_b;
    for (int i = 0; i < 2; i++) if (b_wen && b_be[i]) nw[8*i +: 8] = b_wdata[8*i +: 8];
    bwe = b_req && b_wen && b_in;
    e = '0;
    if (a_req) begin
      e.av = 1'b1;
      e.ae = !a_in;
      if (a_in) e.ad = (mode && bwe && a_addr == b_addr) ? nw : old_a;
    end
    if (b_req) begin
      e.bv = 1'b1;
      e.be = !b_in;
      if (b_in) e.bd = mode ? nw : old_b;
    end
    if (bwe) begin
      if (d == 0) m0[b_addr] = nw;
      else        m1[b_addr] = nw;
    end
  endtask

  task automatic check_out(input string tag, input int d, input exp_t e);
    logic        av, ae, bv, be;
    logic [15:0] ad, bd;
    if (d == 0) begin av = av0; ae = ae0; ad = ad0; bv = bv0; be = berr0; bd = bd0; end
    else        begin av = av1; ae = ae1; ad = ad1; bv = bv1; be = berr1; bd = bd1; end
    check({tag, "_a_valid"}, 32'(av), 32'(e.av));
    if (e.av) begin
      check({tag, "_a_err"}, 32'(ae), 32'(e.ae));
      check({tag, "_a_rdata"}, 32'(ad), 32'(e.ad));
    end
    check({tag, "_b_valid"}, 32'(bv), 32'(e.bv));
    if (e.bv) begin
      check({tag, "_b_err"}, 32'(be), 32'(e.be));
      check({tag, "_b_rdata"}, 32'(bd), 32'(e.bd));
    end
  endtask

  task automatic model_cycle(input string tag);
    exp_t e0, e1;
    model_step(0, e0);
    model_step(1, e1);
    @(posedge clk); #1;
    check_out({tag, "_d0"}, 0, e0);
    check_out({tag, "_d1"}, 1, e1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl_d0"}, 32'({rdy0, av0, ae0, bv0, berr0}), 32'd0);
    check({tag, "_data_d0"}, {ad0, bd0}, 32'd0);
    check({tag, "_ctl_d1"}, 32'({rdy1, av1, ae1, bv1, berr1}), 32'd0);
    check({tag, "_data_d1"}, {ad1, bd1}, 32'd0);
  endtask

  // Random requests while clearing: nothing may be accepted
  task automatic quiet_cycle(input string tag);
    @(negedge clk);
    drive_random();
    @(posedge clk); #1;
    check({tag, "_d0"}, 32'({rdy0, av0, bv0}), 32'd0);
    check({tag, "_d1"}, 32'({rdy1, av1, bv1}), 32'd0);
  endtask

  // Release reset, optionally issue ignored requests, and count edges until ready
  task automatic release_and_wait(input string tag, input int req_cycles);
    int n0, n1;
    n0 = -1; n1 = -1;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) @(negedge clk);
      if (n <= req_cycles) drive_random();
      else drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
      @(posedge clk); #1;
      if (n <= req_cycles) begin
        check({tag, "_quiet_d0"}, 32'({rdy0, av0, bv0}), 32'd0);
        check({tag, "_quiet_d1"}, 32'({rdy1, av1, bv1}), 32'd0);
      end
      if (n0 < 0 && rdy0) n0 = n;
      if (n1 < 0 && rdy1) n1 = n;
      if (n0 >= 0 && n1 >= 0 && n >= req_cycles) break;
    end
    check({tag, "_ready_edges_d0"}, 32'(n0), 32'd256);
    check({tag, "_ready_edges_d1"}, 32'(n1), 32'd200);
  endtask

  vec_t tbl [16];

  initial begin
    // a_req a_addr b_req b_wen b_be b_addr b_wdata  exp(dut0 read-first/256)  exp(dut1 write-first/200)
    tbl[0]  = '{1'b1, 8'h05, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000,
                mk(1, 0, 16'h0000, 0, 0, 16'h0000), mk(1, 0, 16'h0000, 0, 0, 16'h0000)};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 8'h10, 16'hBEEF,
                mk(0, 0, 16'h0000, 1, 0, 16'h0000), mk(0, 0, 16'h0000, 1, 0, 16'hBEEF)};
    tbl[2]  = '{1'b1, 8'h10, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000,
                mk(1, 0, 16'hBEEF, 0, 0, 16'h0000), mk(1, 0, 16'hBEEF, 0, 0, 16'h0000)};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 8'h10, 16'h1234,
                mk(0, 0, 16'h0000, 1, 0, 16'hBEEF), mk(0, 0, 16'h0000, 1, 0, 16'hBE34)};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b11, 8'h10, 16'h0000,
                mk(0, 0, 16'h0000, 1, 0, 16'hBE34), mk(0, 0, 16'h0000, 1, 0, 16'hBE34)};
    tbl[5]  = '{1'b1, 8'h10, 1'b1, 1'b1, 2'b11, 8'h10, 16'h5555,
                mk(1, 0, 16'hBE34, 1, 0, 16'hBE34), mk(1, 0, 16'h5555, 1, 0, 16'h5555)};
    tbl[6]  = '{1'b1, 8'h10, 1'b1, 1'b0, 2'b11, 8'h10, 16'h0000,
                mk(1, 0, 16'h5555, 1, 0, 16'h5555), mk(1, 0, 16'h5555, 1, 0, 16'h5555)};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 8'hC8, 16'hFFFF,
                mk(0, 0, 16'h0000, 1, 0, 16'h0000), mk(0, 0, 16'h0000, 1, 1, 16'h0000)};
    tbl[8]  = '{1'b1, 8'hC8, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000,
                mk(1, 0, 16'hFFFF, 0, 0, 16'h0000), mk(1, 1, 16'h0000, 0, 0, 16'h0000)};
    tbl[9]  = '{1'b1, 8'hC7, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000,
                mk(1, 0, 16'h0000, 0, 0, 16'h0000), mk(1, 0, 16'h0000, 0, 0, 16'h0000)};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 8'h20, 16'hABCD,
                mk(0, 0, 16'h0000, 1, 0, 16'h0000), mk(0, 0, 16'h0000, 1, 0, 16'h0000)};
    tbl[11] = '{1'b1, 8'h20, 1'b1, 1'b0, 2'b00, 8'hFF, 16'h0000,
                mk(1, 0, 16'h0000, 1, 0, 16'h0000), mk(1, 0, 16'h0000, 1, 1, 16'h0000)};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 8'h30, 16'hA5C3,
                mk(0, 0, 16'h0000, 1, 0, 16'h0000), mk(0, 0, 16'h0000, 1, 0, 16'hA500)};
    tbl[13] = '{1'b1, 8'h30, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000,
                mk(1, 0, 16'hA500, 0, 0, 16'h0000), mk(1, 0, 16'hA500, 0, 0, 16'h0000)};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b11, 8'h30, 16'h9999,
                mk(0, 0, 16'h0000, 0, 0, 16'h0000), mk(0, 0, 16'h0000, 0, 0, 16'h0000)};
    tbl[15] = '{1'b1, 8'h30, 1'b1, 1'b1, 2'b11, 8'h31, 16'h1111,
                mk(1, 0, 16'hA500, 1, 0, 16'h0000), mk(1, 0, 16'hA500, 1, 0, 16'h1111)};

    for (int i = 0; i < 256; i++) begin m0[i] = '0; m1[i] = '0; end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    repeat (3) @(posedge clk);
    #1 check_reset("por");

    release_and_wait("t1", 0);

    // Directed vectors; the model is stepped alongside to keep its memory in sync
    foreach (tbl[i]) begin
      exp_t e0, e1;
      @(negedge clk);
      drive(tbl[i].a_req, tbl[i].a_addr, tbl[i].b_req, tbl[i].b_wen, tbl[i].b_be,
            tbl[i].b_addr, tbl[i].b_wdata);
      model_step(0, e0);
      model_step(1, e1);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d_d0", i), 0, tbl[i].e0);
      check_out($sformatf("vec%0d_d1", i), 1, tbl[i].e1);
    end

    // Randomized traffic at full throughput against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive_random();
      model_cycle("rand");
    end

    // Asynchronous reset from READY, then a second reset in the middle of the clear
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset("rst_ready");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) quiet_cycle("init_req");
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset("rst_mid_init");
    repeat (3) @(posedge clk);
    release_and_wait("t6", 150);

    // Every entry reads back zero after the restarted clear
    for (int i = 0; i < 256; i++) begin m0[i] = '0; m1[i] = '0; end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(i), 1'b1, 1'b0, 2'b00, 8'(255 - i), 16'h0000);
      model_cycle("readback");
    end

    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    @(posedge clk); #1;
    check("idle_d0", 32'({av0, bv0}), 32'd0);
    check("idle_d1", 32'({av1, bv1}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
